// File: rtl/quiz_pkg.sv
// Shared definitions for the buzzer quiz round controller: state encoding,
// player count, countdown width and round-robin arbitration helpers.
package quiz_pkg;

  localparam int NUM_PLAYERS = 4;
  localparam int SEC_W       = 5;
  localparam int PTR_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ANSWER = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // One-hot grant of the first requester at or after ptr, wrapping around.
  function automatic logic [NUM_PLAYERS-1:0] rr_pick(input logic [NUM_PLAYERS-1:0] req,
                                                     input logic [PTR_W-1:0]       ptr);
    logic [NUM_PLAYERS-1:0] grant;
    logic [PTR_W-1:0]       idx;
    grant = {NUM_PLAYERS{1'b0}};
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) begin
        grant      = {NUM_PLAYERS{1'b0}};
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [PTR_W-1:0] oh_index(input logic [NUM_PLAYERS-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: registered one-cycle tick every CLK_HZ cycles,
// restarted from zero by clear. CLK_HZ must be at least 2.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 2;

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Tick is raised one cycle early so it is consumed on the CLK_HZ-th edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == CW'(CLK_HZ - 1)) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= (cnt_r == CW'(CLK_HZ - 2));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/buzz_round_ctrl.sv
// Quiz buzzer round controller: synchronized buzz edges, round-robin grant,
// countdowns, verdict scoring and alarm. False-start fouls: BUZZ_FALSE_START_EN.
module buzz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int WINDOW_SEC = 30,
  parameter int ANSWER_SEC = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_PLAYERS-1:0] buzz,
  input  logic                   judge_yes,
  input  logic                   judge_no,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic [1:0]             state_o,
  output logic [SEC_W-1:0]       secs_left,
  output logic [NUM_PLAYERS-1:0] score_inc,
  output logic [NUM_PLAYERS-1:0] score_dec,
  output logic                   alarm_en,
  output logic [NUM_PLAYERS-1:0] foul
);

  localparam int AW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 2;

  state_e                 state_r, state_nx_s;
  logic [NUM_PLAYERS-1:0] sync1_r, sync2_r, prev_r, edge_s, elig_s, fs_edge_s, grant_s;
  logic [NUM_PLAYERS-1:0] winner_r, winner_nx_s, inc_r, inc_nx_s, dec_r, dec_nx_s;
  logic [NUM_PLAYERS-1:0] foul_r, foul_nx_s;
  logic [SEC_W-1:0]       secs_r, secs_nx_s;
  logic [PTR_W-1:0]       ptr_r, ptr_nx_s;
  logic                   alarm_r, alarm_load_s, tick_s, clear_s;
  logic [AW-1:0]          alarm_cnt_r;

  assign edge_s  = sync2_r & ~prev_r;
`ifdef BUZZ_FALSE_START_EN
  assign elig_s    = edge_s & ~foul_r;
  assign fs_edge_s = edge_s;
`else
  assign elig_s    = edge_s;
  assign fs_edge_s = {NUM_PLAYERS{1'b0}};
`endif
  assign grant_s = rr_pick(elig_s, ptr_r);
  assign clear_s = (state_nx_s != state_r);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Two-flop synchronizer plus previous-value flop for rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {NUM_PLAYERS{1'b0}};
      sync2_r <= {NUM_PLAYERS{1'b0}};
      prev_r  <= {NUM_PLAYERS{1'b0}};
    end else begin
      sync1_r <= buzz;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Round sequencing: next state and next datapath values.
  always_comb begin
    state_nx_s   = state_r;
    winner_nx_s  = winner_r;
    secs_nx_s    = secs_r;
    ptr_nx_s     = ptr_r;
    foul_nx_s    = foul_r;
    inc_nx_s     = {NUM_PLAYERS{1'b0}};
    dec_nx_s     = {NUM_PLAYERS{1'b0}};
    alarm_load_s = 1'b0;
    if (abort) begin
      state_nx_s  = ST_IDLE;
      winner_nx_s = {NUM_PLAYERS{1'b0}};
      secs_nx_s   = {SEC_W{1'b0}};
      foul_nx_s   = {NUM_PLAYERS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_RESULT: begin
          foul_nx_s = foul_r | fs_edge_s;
          if (start) begin
            state_nx_s  = ST_ARMED;
            secs_nx_s   = SEC_W'(WINDOW_SEC);
            winner_nx_s = {NUM_PLAYERS{1'b0}};
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_ARMED: begin
          if (|grant_s) begin
            state_nx_s   = ST_ANSWER;
            winner_nx_s  = grant_s;
            secs_nx_s    = SEC_W'(ANSWER_SEC);
            ptr_nx_s     = oh_index(grant_s) + PTR_W'(1);
            alarm_load_s = 1'b1;
            foul_nx_s    = {NUM_PLAYERS{1'b0}};
          end else if (tick_s && (secs_r <= SEC_W'(1))) begin
            state_nx_s  = ST_RESULT;
            winner_nx_s = {NUM_PLAYERS{1'b0}};
            secs_nx_s   = {SEC_W{1'b0}};
            foul_nx_s   = {NUM_PLAYERS{1'b0}};
          end else if (tick_s) begin
            secs_nx_s = secs_r - SEC_W'(1);
          end else begin
            secs_nx_s = secs_r;
          end
        end
        ST_ANSWER: begin
          if (judge_yes) begin
            state_nx_s = ST_RESULT;
            inc_nx_s   = winner_r;
            secs_nx_s  = {SEC_W{1'b0}};
          end else if (judge_no) begin
            state_nx_s = ST_RESULT;
            dec_nx_s   = winner_r;
            secs_nx_s  = {SEC_W{1'b0}};
          end else if (tick_s && (secs_r <= SEC_W'(1))) begin
            state_nx_s   = ST_RESULT;
            dec_nx_s     = winner_r;
            secs_nx_s    = {SEC_W{1'b0}};
            alarm_load_s = 1'b1;
          end else if (tick_s) begin
            secs_nx_s = secs_r - SEC_W'(1);
          end else begin
            secs_nx_s = secs_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nx_s;
  end

  // Registered datapath and output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_r <= {NUM_PLAYERS{1'b0}};
      secs_r   <= {SEC_W{1'b0}};
      ptr_r    <= {PTR_W{1'b0}};
      foul_r   <= {NUM_PLAYERS{1'b0}};
      inc_r    <= {NUM_PLAYERS{1'b0}};
      dec_r    <= {NUM_PLAYERS{1'b0}};
    end else begin
      winner_r <= winner_nx_s;
      secs_r   <= secs_nx_s;
      ptr_r    <= ptr_nx_s;
      foul_r   <= foul_nx_s;
      inc_r    <= inc_nx_s;
      dec_r    <= dec_nx_s;
    end
  end

  // Beeper: high for exactly CLK_HZ cycles after each load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= {AW{1'b0}};
    end else if (abort) begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= {AW{1'b0}};
    end else if (alarm_load_s) begin
      alarm_r     <= 1'b1;
      alarm_cnt_r <= AW'(CLK_HZ - 1);
    end else if (alarm_r && (alarm_cnt_r == {AW{1'b0}})) begin
      alarm_r <= 1'b0;
    end else if (alarm_r) begin
      alarm_cnt_r <= alarm_cnt_r - AW'(1);
    end
  end

  assign winner    = winner_r;
  assign state_o   = state_r;
  assign secs_left = secs_r;
  assign score_inc = inc_r;
  assign score_dec = dec_r;
  assign alarm_en  = alarm_r;
  assign foul      = foul_r;

endmodule

// File: doc/buzz_round_ctrl.md
BUZZ_ROUND_CTRL -- requirements
Module: buzz_round_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter WINDOW_SEC, default 30, buzz-window length in seconds.
REQ-003 SHALL have parameter ANSWER_SEC, default 10, answer-time length in seconds.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  host level: arm a new round.
REQ-007 SHALL have port abort  in  1  host level: cancel round, return to IDLE.
REQ-008 SHALL have port buzz  in  4  player buttons, asynchronous, active-high.
REQ-009 SHALL have port judge_yes  in  1  host verdict: correct.
REQ-010 SHALL have port judge_no  in  1  host verdict: wrong.
REQ-011 SHALL have port winner  out  4  one-hot granted player; 0 means none.
REQ-012 SHALL have port state_o  out  2  current FSM state code.
REQ-013 SHALL have port secs_left  out  5  seconds remaining in the active countdown.
REQ-014 SHALL have port score_inc  out  4  one-cycle one-hot pulse: award a point.
REQ-015 SHALL have port score_dec  out  4  one-cycle one-hot pulse: deduct a point.
REQ-016 SHALL have port alarm_en  out  1  beeper enable.
REQ-017 SHALL have port foul  out  4  sticky false-start flags.

Function
REQ-018 SHALL pass buzz through a 2-flop synchronizer and act only on rising edges of the synchronized signals.
REQ-019 SHALL implement states IDLE=0, ARMED=1, ANSWER=2, RESULT=3.
REQ-020 SHALL transition IDLE->ARMED or RESULT->ARMED on the first cycle start is high, loading secs_left=WINDOW_SEC and clearing winner.
REQ-021 SHALL, in ARMED, grant the first eligible buzz edge: winner set, secs_left=ANSWER_SEC, ->ANSWER in the next cycle.
REQ-022 SHALL, on simultaneous edges, arbitrate round-robin: the priority pointer starts at player 0 and moves to (winner+1) mod 4 after every grant.
REQ-023 SHALL ignore all buzz edges outside ARMED, except as specified by REQ-034.
REQ-024 SHALL decrement secs_left once per 1 s tick, and on reaching 0 move ARMED->RESULT with winner=0.
REQ-025 SHALL, in ANSWER: judge_yes pulses score_inc=winner for one cycle and goes to RESULT; judge_no, or the countdown reaching 0, pulses score_dec=winner and goes to RESULT.
REQ-026 SHALL give judge_yes priority over judge_no when both are high in the same cycle.
REQ-027 SHALL assert alarm_en for exactly CLK_HZ cycles (1 s) starting on the cycle after a grant, and on an ANSWER timeout.
REQ-028 SHALL hold winner in RESULT until start or abort.
REQ-029 SHALL make abort in any state go to IDLE within one cycle, clear winner, alarm_en and foul, and emit no score pulse; abort overrides start.
REQ-030 SHALL restart the 1 s prescaler from zero on every state entry.

Reset
REQ-031 SHALL, while rst is low: state=IDLE, winner=0, secs_left=0, score_inc=0, score_dec=0, alarm_en=0, foul=0, priority pointer=0, prescaler=0, synchronizers=0.
REQ-032 SHALL make reset asserted mid-round discard the round with no score pulse.

Configuration
REQ-033 SHALL gate false-start detection with macro BUZZ_FALSE_START_EN.
REQ-034 SHALL, when the macro is defined: a buzz edge in IDLE or RESULT sets that player's foul bit; fouled players are ineligible in the next ARMED; foul clears when that ARMED period exits.
REQ-035 SHALL, when the macro is undefined: tie foul to 0 and leave eligibility unaffected.

Structure
REQ-036 SHALL place the state encoding, NUM_PLAYERS=4 and the seconds width in shared package quiz_pkg.
REQ-037 SHALL implement the 1 s prescaler as sub-module sec_tick_gen, with a clear input and a one-cycle tick output.

Verification
REQ-038 SHALL cover: start, then buzz[2] edge -> winner=0100, state ANSWER, secs_left=ANSWER_SEC, alarm_en high for CLK_HZ cycles.
REQ-039 SHALL cover: buzz[0] and buzz[3] edges in the same cycle on the first round -> winner=0001; on the next round a repeat of the same tie -> winner=1000.
REQ-040 SHALL cover: grant of player 1, then judge_yes and judge_no high together -> score_inc=0010 for one cycle, score_dec stays 0.
REQ-041 SHALL cover: grant with no verdict for ANSWER_SEC ticks -> score_dec pulse equal to winner, alarm_en asserted, state RESULT.
REQ-042 SHALL cover: with the macro defined, buzz[1] edge in IDLE then start -> foul=0010, buzz[1] edge ignored, buzz[0] edge granted.
REQ-043 SHALL cover: abort or rst asserted in ANSWER -> IDLE, winner=0, no score pulse.
